// File: rtl/cnn_infer_sequencer.sv
// Top-level scheduler for the CNN inference datapath:
// image load -> conv start -> result collection -> done, with a stall watchdog.
module cnn_infer_sequencer #(
    parameter int NUM_PIXELS    = 64,
    parameter int NUM_POSITIONS = 36,
    parameter int TIMEOUT_CYC   = 1023,
    localparam int AW = $clog2(NUM_PIXELS),
    localparam int IW = $clog2(NUM_POSITIONS),
    localparam int PW = $clog2(NUM_POSITIONS + 1),
    localparam int WW = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ena,
    input  logic          restart,
    input  logic          pix_valid,
    output logic          buf_we,
    output logic [AW-1:0] buf_addr,
    output logic          conv_start,
    input  logic          conv_valid,
    input  logic          pipe_valid,
    output logic          res_capture,
    output logic [IW-1:0] res_index,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5,
        ERROR = 3'd6
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] pix_cnt, pix_nxt;
    logic [PW-1:0] pos_cnt, pos_nxt;
    logic [PW-1:0] res_cnt, res_nxt;
    logic [WW-1:0] wdog, wdog_nxt, wdog_inc;
    logic          active, hit, res_full;

    assign active   = (state == RUN) || (state == DRAIN);
    assign hit      = conv_valid | pipe_valid;
    assign res_full = (res_cnt >= PW'(NUM_POSITIONS));
    assign wdog_inc = wdog + 1'b1;

    // restart wins over any write or capture in the same cycle
    assign buf_we      = (state == LOAD) & pix_valid & ena & ~restart;
    assign res_capture = active & pipe_valid & ena & ~restart & ~res_full;
    assign conv_start  = (state == START) & ena;

    assign buf_addr  = pix_cnt;
    assign res_index = res_full ? IW'(NUM_POSITIONS - 1) : IW'(res_cnt);
    assign busy      = (state == LOAD) || (state == START) || active;
    assign done      = (state == DONE);
    assign err       = (state == ERROR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pix_cnt <= '0;
            pos_cnt <= '0;
            res_cnt <= '0;
            wdog    <= '0;
        end else begin
            state   <= state_nxt;
            pix_cnt <= pix_nxt;
            pos_cnt <= pos_nxt;
            res_cnt <= res_nxt;
            wdog    <= wdog_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pix_nxt   = pix_cnt;
        pos_nxt   = pos_cnt;
        res_nxt   = res_cnt;
        wdog_nxt  = wdog;
        if (ena) begin
            if (restart) begin
                state_nxt = LOAD;
                pix_nxt   = '0;
                pos_nxt   = '0;
                res_nxt   = '0;
                wdog_nxt  = '0;
            end else begin
                unique case (state)
                    IDLE:  state_nxt = LOAD;
                    LOAD: begin
                        if (buf_we) begin
                            pix_nxt = pix_cnt + 1'b1;
                            if (pix_cnt == AW'(NUM_PIXELS - 1)) begin
                                state_nxt = START;
                                pix_nxt   = '0;
                            end
                        end
                    end
                    START: state_nxt = RUN;
                    RUN, DRAIN: begin
                        wdog_nxt = hit ? '0 : wdog_inc;
                        if (res_capture)
                            res_nxt = res_cnt + 1'b1;
                        if (state == RUN && conv_valid) begin
                            pos_nxt = pos_cnt + 1'b1;
                            if (pos_cnt == PW'(NUM_POSITIONS - 1))
                                state_nxt = DRAIN;
                        end
                        // leave DRAIN once the last result is (or already was) taken
                        if (state == DRAIN &&
                            (res_full ||
                             (res_capture &&
                              res_cnt == PW'(NUM_POSITIONS - 1))))
                            state_nxt = DONE;
                        if (!hit && wdog_inc == WW'(TIMEOUT_CYC))
                            state_nxt = ERROR;
                    end
                    default: ;
                endcase
                if (state_nxt != state)
                    wdog_nxt = '0;
            end
        end
    end

endmodule

// File: tb/tb_cnn_infer_sequencer.sv
// Directed self-checking bench for cnn_infer_sequencer.
// Inputs change 2-3 ns after each rising edge; outputs are checked 1 ns later.
module tb_cnn_infer_sequencer;

    logic       clk = 1'b0;
    logic       reset, ena, restart, pix_valid;
    logic       conv_valid, pipe_valid;
    logic       buf_we, conv_start, res_capture;
    logic       busy, done, err;
    logic [5:0] buf_addr, res_index;

    int checks = 0;
    int errors = 0;
    int ncap, w;

    always #5 clk = ~clk;

    cnn_infer_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .ena         (ena),
        .restart     (restart),
        .pix_valid   (pix_valid),
        .buf_we      (buf_we),
        .buf_addr    (buf_addr),
        .conv_start  (conv_start),
        .conv_valid  (conv_valid),
        .pipe_valid  (pipe_valid),
        .res_capture (res_capture),
        .res_index   (res_index),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_we"}, 32'(buf_we), 0);
        chk({tag, "_addr"}, 32'(buf_addr), 0);
        chk({tag, "_start"}, 32'(conv_start), 0);
        chk({tag, "_cap"}, 32'(res_capture), 0);
        chk({tag, "_idx"}, 32'(res_index), 0);
    endtask

    // 64 back-to-back pixels from LOAD, then START pulse, ending in RUN
    task automatic load_all(input string tag);
        for (int i = 0; i < 64; i++) begin
            pix_valid = 1'b1;
            #1;
            chk({tag, "_we"}, 32'(buf_we), 1);
            chk({tag, "_addr"}, 32'(buf_addr), 32'(i));
            chk({tag, "_nostart"}, 32'(conv_start), 0);
            tick;
        end
        pix_valid = 1'b0;
        #1;
        chk({tag, "_start"}, 32'(conv_start), 1);
        chk({tag, "_start_we"}, 32'(buf_we), 0);
        tick;
        #1;
        chk({tag, "_start_off"}, 32'(conv_start), 0);
        chk({tag, "_run_busy"}, 32'(busy), 1);
    endtask

    task automatic do_restart(input string tag);
        restart = 1'b1;
        tick;
        restart    = 1'b0;
        conv_valid = 1'b0;
        pipe_valid = 1'b0;
        #1;
        chk({tag, "_busy"}, 32'(busy), 1);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_addr"}, 32'(buf_addr), 0);
        chk({tag, "_idx"}, 32'(res_index), 0);
    endtask

    initial begin
        reset = 1'b1; ena = 1'b0; restart = 1'b0;
        pix_valid = 1'b0; conv_valid = 1'b0; pipe_valid = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        #1;
        idle_outputs("rst");

        // 1: back-to-back load
        ena = 1'b1;
        tick;
        load_all("t1");

        // 3: conv_valid then pipe_valid 3 cycles later, 36 times
        for (int k = 0; k < 36; k++) begin
            conv_valid = 1'b1;
            #1;
            chk("t3_nocap", 32'(res_capture), 0);
            tick;
            conv_valid = 1'b0;
            tick;
            tick;
            pipe_valid = 1'b1;
            #1;
            chk("t3_cap", 32'(res_capture), 1);
            chk("t3_idx", 32'(res_index), 32'(k));
            chk("t3_notdone", 32'(done), 0);
            tick;
            pipe_valid = 1'b0;
        end
        #1;
        chk("t3_done", 32'(done), 1);
        chk("t3_busy", 32'(busy), 0);
        chk("t3_idx_sat", 32'(res_index), 35);

        // pulses in DONE are ignored
        conv_valid = 1'b1;
        pipe_valid = 1'b1;
        #1;
        chk("t3_done_cap", 32'(res_capture), 0);
        tick;
        conv_valid = 1'b0;
        pipe_valid = 1'b0;
        #1;
        chk("t3_done_hold", 32'(done), 1);

        // 4: 40 pipe_valid pulses in RUN, only 36 captured
        do_restart("t4_rs");
        load_all("t4");
        ncap = 0;
        for (int i = 0; i < 40; i++) begin
            pipe_valid = 1'b1;
            #1;
            chk("t4_cap", 32'(res_capture), 32'(i < 36));
            chk("t4_idx", 32'(res_index), 32'((i < 36) ? i : 35));
            if (res_capture) ncap++;
            tick;
        end
        pipe_valid = 1'b0;
        chk("t4_ncap", 32'(ncap), 36);
        for (int i = 0; i < 36; i++) begin
            conv_valid = 1'b1;
            #1;
            chk("t4_run_busy", 32'(busy), 1);
            chk("t4_run_done", 32'(done), 0);
            tick;
        end
        conv_valid = 1'b0;
        #1;
        chk("t4_drain_busy", 32'(busy), 1);
        chk("t4_drain_done", 32'(done), 0);
        tick;
        #1;
        chk("t4_done", 32'(done), 1);
        conv_valid = 1'b1;
        pipe_valid = 1'b1;
        #1;
        chk("t4_done_cap", 32'(res_capture), 0);
        tick;
        conv_valid = 1'b0;
        pipe_valid = 1'b0;
        #1;
        chk("t4_done_hold", 32'(done), 1);
        chk("t4_done_idx", 32'(res_index), 35);

        // 2: gapped pixels with ena toggling
        do_restart("t2_rs");
        w = 0;
        for (int c = 0; c < 500 && w < 64; c++) begin
            pix_valid = (c % 3 != 2);
            ena       = (c % 7 != 5);
            #1;
            chk("t2_we", 32'(buf_we), 32'(pix_valid & ena));
            chk("t2_addr", 32'(buf_addr), 32'(w));
            if (pix_valid && ena) w++;
            tick;
        end
        pix_valid = 1'b0;
        ena       = 1'b1;
        chk("t2_writes", 32'(w), 64);
        #1;
        chk("t2_start", 32'(conv_start), 1);
        tick;
        #1;
        chk("t2_start_off", 32'(conv_start), 0);

        // 5: 10 positions then stall until the watchdog fires
        for (int i = 0; i < 10; i++) begin
            conv_valid = 1'b1;
            pipe_valid = 1'b1;
            #1;
            chk("t5_cap", 32'(res_capture), 1);
            chk("t5_idx", 32'(res_index), 32'(i));
            tick;
        end
        conv_valid = 1'b0;
        pipe_valid = 1'b0;
        for (int j = 1; j <= 1023; j++) begin
            #1;
            chk("t5_noerr", 32'(err), 0);
            tick;
        end
        #1;
        chk("t5_err", 32'(err), 1);
        chk("t5_busy", 32'(busy), 0);
        do_restart("t5_rs");

        // 6: restart mid-RUN at position 20, then reset mid-LOAD
        load_all("t6");
        for (int i = 0; i < 20; i++) begin
            conv_valid = 1'b1;
            pipe_valid = 1'b1;
            tick;
        end
        #1;
        chk("t6_idx20", 32'(res_index), 20);
        do_restart("t6_rs");
        for (int i = 0; i < 10; i++) begin
            pix_valid = 1'b1;
            #1;
            chk("t6_addr", 32'(buf_addr), 32'(i));
            tick;
        end
        reset = 1'b1;
        tick;
        reset     = 1'b0;
        pix_valid = 1'b0;
        #1;
        idle_outputs("t6_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
